// File: rtl/ex_shad_pipe64.sv
// ex_shad_pipe64: two-stage 64-bit SHLD/SHAD execute slot.
// Stage 1 holds the issued operands, the shift is evaluated between
// stage 1 and stage 2, and stage 2 holds the result for writeback.
// Optional feature macro: EXSHAD_TBIT_EN adds outT, the last bit shifted out.
module ex_shad_pipe64 #(
  parameter int TAG_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             inValid,
  output logic             inReady,
  input  logic [63:0]      inRs,
  input  logic [7:0]       inRt,
  input  logic [2:0]       inOp,
  input  logic [TAG_W-1:0] inTag,
  output logic             outValid,
  input  logic             outReady,
  output logic [63:0]      outRn,
  output logic [TAG_W-1:0] outTag
`ifdef EXSHAD_TBIT_EN
  ,
  output logic             outT
`endif
);

  // Effective 8-bit count: reversed ops negate, pass ops shift by zero.
  function automatic logic [7:0] shift_count(input logic [7:0] rt, input logic [2:0] op);
    case (op)
      3'd1, 3'd2: return rt;
      3'd3, 3'd4: return 8'd0 - rt;
      default:    return 8'd0;
    endcase
  endfunction

  // Count bit 7 selects direction; bit 6 is ignored. A right shift moves by
  // 64 - count[5:0], so count 0x80 is a full 64-bit right shift.
  function automatic logic [63:0] shad_result(input logic [63:0] rs, input logic [7:0] sh,
                                              input logic arith);
    logic signed [63:0] rs_s;
    logic signed [63:0] ars;
    logic [6:0]         m;
    rs_s = signed'(rs);
    if (!sh[7]) return rs << sh[5:0];
    m   = 7'd64 - {1'b0, sh[5:0]};
    ars = rs_s >>> m;
    if (arith) return unsigned'(ars);
    return rs >> m;
  endfunction

`ifdef EXSHAD_TBIT_EN
  // Last bit leaving the register: rs[64-n] for left shifts, rs[m-1] for
  // right shifts (rs[63] when m = 64), zero when nothing moves.
  function automatic logic shad_tbit(input logic [63:0] rs, input logic [7:0] sh);
    logic [63:0] tmp;
    logic [6:0]  idx;
    if (!sh[7]) begin
      if (sh[5:0] == 6'd0) return 1'b0;
      idx = 7'd64 - {1'b0, sh[5:0]};
    end else begin
      idx = 7'd63 - {1'b0, sh[5:0]};
    end
    tmp = rs >> idx;
    return tmp[0];
  endfunction
`endif

  logic             vld_p1;
  logic [63:0]      rs_p1;
  logic [7:0]       rt_p1;
  logic [2:0]       op_p1;
  logic [TAG_W-1:0] tag_p1;
  logic             vld_p2;
  logic [63:0]      rn_p2;
  logic [TAG_W-1:0] tag_p2;

  logic             s2_free;
  logic             issue;
  logic             advance;
  logic [7:0]       sh_p1;
  logic             arith_p1;
  logic [63:0]      res_p1;

  // Handshake and shift evaluation between the two stages.
  always_comb begin
    s2_free  = !vld_p2 || outReady;
    inReady  = !vld_p1 || s2_free;
    issue    = inValid && inReady;
    advance  = vld_p1 && s2_free;
    sh_p1    = shift_count(rt_p1, op_p1);
    arith_p1 = (op_p1 == 3'd2) || (op_p1 == 3'd4);
    res_p1   = shad_result(rs_p1, sh_p1, arith_p1);
  end

  // ---- stage 1: issued operands ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p1 <= 1'b0;
      rs_p1  <= '0;
      rt_p1  <= '0;
      op_p1  <= '0;
      tag_p1 <= '0;
    end else begin
      if (flush)        vld_p1 <= 1'b0;
      else if (issue)   vld_p1 <= 1'b1;
      else if (advance) vld_p1 <= 1'b0;
      if (issue && !flush) begin
        rs_p1  <= inRs;
        rt_p1  <= inRt;
        op_p1  <= inOp;
        tag_p1 <= inTag;
      end
    end
  end

  // ---- stage 2: result held for writeback ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p2 <= 1'b0;
      rn_p2  <= '0;
      tag_p2 <= '0;
    end else begin
      if (flush)         vld_p2 <= 1'b0;
      else if (advance)  vld_p2 <= 1'b1;
      else if (outReady) vld_p2 <= 1'b0;
      if (advance && !flush) begin
        rn_p2  <= res_p1;
        tag_p2 <= tag_p1;
      end
    end
  end

`ifdef EXSHAD_TBIT_EN
  logic t_p2;

  // Shifted-out bit travels with the stage-2 result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) t_p2 <= 1'b0;
    else if (advance && !flush) t_p2 <= shad_tbit(rs_p1, sh_p1);
  end

  assign outT = t_p2;
`endif

  assign outValid = vld_p2;
  assign outRn    = rn_p2;
  assign outTag   = tag_p2;

endmodule

// File: tb/tb_ex_shad_pipe64.sv
// Directed bench for ex_shad_pipe64 with hand-computed expected values.
// Define EXSHAD_TBIT_EN to also cover the shifted-out bit output.
module tb_ex_shad_pipe64;
  localparam int TAG_W = 6;

  logic             clock = 1'b0;
  logic             reset;
  logic             flush;
  logic             inValid;
  logic             inReady;
  logic [63:0]      inRs;
  logic [7:0]       inRt;
  logic [2:0]       inOp;
  logic [TAG_W-1:0] inTag;
  logic             outValid;
  logic             outReady;
  logic [63:0]      outRn;
  logic [TAG_W-1:0] outTag;
`ifdef EXSHAD_TBIT_EN
  logic             outT;
`endif

  int errs   = 0;
  int checks = 0;

  ex_shad_pipe64 #(.TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .inValid(inValid), .inReady(inReady), .inRs(inRs), .inRt(inRt),
    .inOp(inOp), .inTag(inTag),
    .outValid(outValid), .outReady(outReady), .outRn(outRn), .outTag(outTag)
`ifdef EXSHAD_TBIT_EN
    , .outT(outT)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue one op with outReady=1 and check the result two edges later.
  task automatic run_op(input string name, input logic [63:0] rs, input logic [7:0] rt,
                        input logic [2:0] op, input logic [TAG_W-1:0] tag,
                        input logic [63:0] exp);
    inValid = 1'b1; inRs = rs; inRt = rt; inOp = op; inTag = tag;
    step();
    inValid = 1'b0;
    chk({name, "_lat1"}, {63'd0, outValid}, 64'd0);
    step();
    chk({name, "_vld"}, {63'd0, outValid}, 64'd1);
    chk({name, "_rn"},  outRn, exp);
    chk({name, "_tag"}, {58'd0, outTag}, {58'd0, tag});
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; inValid = 1'b0; inRs = '0; inRt = '0;
    inOp = '0; inTag = '0; outReady = 1'b1;
    #3;
    chk("rst_vld",   {63'd0, outValid}, 64'd0);
    chk("rst_ready", {63'd0, inReady},  64'd1);
    chk("rst_rn",    outRn, 64'd0);
    chk("rst_tag",   {58'd0, outTag}, 64'd0);
    step();
    reset = 1'b1;
    step();

    // Directed shift vectors
    run_op("shld_l63",   64'h1,                 8'h3F, 3'd1, 6'd5,  64'h8000_0000_0000_0000);
    run_op("shad_r64",   64'h8000_0000_0000_0000, 8'hC0, 3'd2, 6'd6,  64'hFFFF_FFFF_FFFF_FFFF);
    run_op("shadr_r4",   64'h8000_0000_0000_0000, 8'h04, 3'd4, 6'd7,  64'hF800_0000_0000_0000);
    run_op("op6_pass",   64'h1234,              8'h05, 3'd6, 6'd8,  64'h1234);
    run_op("shld_40",    64'h1234,              8'h40, 3'd1, 6'd9,  64'h1234);
    run_op("shld_80",    64'hFFFF_FFFF_FFFF_FFFF, 8'h80, 3'd1, 6'd10, 64'h0);
    run_op("shldr_m128", 64'h8000_0000_0000_0000, 8'h80, 3'd3, 6'd11, 64'h0);
    run_op("shadr_m128", 64'h8000_0000_0000_0000, 8'h80, 3'd4, 6'd12, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("shld_r4",    64'hF000_0000_0000_0000, 8'hFC, 3'd1, 6'd13, 64'h0F00_0000_0000_0000);
    run_op("shld_l4",    64'h1,                 8'h04, 3'd1, 6'd14, 64'h10);
    run_op("shlc_0",     64'hABCD,              8'h00, 3'd1, 6'd15, 64'hABCD);
`ifdef EXSHAD_TBIT_EN
    run_op("t_l63",      64'h3,                 8'h3F, 3'd1, 6'd16, 64'h8000_0000_0000_0000);
    chk("t_l63_t", {63'd0, outT}, 64'd1);
    run_op("t_r4",       64'h8,                 8'hFC, 3'd1, 6'd17, 64'h0);
    chk("t_r4_t", {63'd0, outT}, 64'd1);
    run_op("t_r64",      64'h8000_0000_0000_0000, 8'h80, 3'd2, 6'd18, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t_r64_t", {63'd0, outT}, 64'd1);
    run_op("t_none",     64'hFFFF,              8'h00, 3'd1, 6'd19, 64'hFFFF);
    chk("t_none_t", {63'd0, outT}, 64'd0);
`endif
    step();
    chk("idle_vld", {63'd0, outValid}, 64'd0);

    // Backpressure: tags 1,2,3 with writeback stalled
    outReady = 1'b0;
    inValid = 1'b1; inOp = 3'd0; inRt = 8'h00; inRs = 64'h101; inTag = 6'd1;
    step();
    inRs = 64'h102; inTag = 6'd2;
    chk("bp_ready1", {63'd0, inReady}, 64'd1);
    step();
    inRs = 64'h103; inTag = 6'd3;
    chk("bp_ready0", {63'd0, inReady}, 64'd0);
    chk("bp_tag1",   {58'd0, outTag}, 64'd1);
    step();
    chk("bp_hold_vld", {63'd0, outValid}, 64'd1);
    chk("bp_hold_tag", {58'd0, outTag}, 64'd1);
    chk("bp_hold_rn",  outRn, 64'h101);
    chk("bp_hold_rdy", {63'd0, inReady}, 64'd0);
    outReady = 1'b1;
    #1;
    chk("bp_rdy_comb", {63'd0, inReady}, 64'd1);
    step();
    inValid = 1'b0;
    chk("drain_tag2", {58'd0, outTag}, 64'd2);
    chk("drain_rn2",  outRn, 64'h102);
    step();
    chk("drain_tag3", {58'd0, outTag}, 64'd3);
    chk("drain_vld3", {63'd0, outValid}, 64'd1);
    step();
    chk("drain_empty", {63'd0, outValid}, 64'd0);

    // Flush with stage 2 valid and a simultaneous issue
    outReady = 1'b0;
    inValid = 1'b1; inRs = 64'h7; inTag = 6'd7;
    step();
    inValid = 1'b0;
    step();
    chk("fl_pre_vld", {63'd0, outValid}, 64'd1);
    inValid = 1'b1; inRs = 64'h9; inTag = 6'd9; flush = 1'b1;
    step();
    inValid = 1'b0; flush = 1'b0;
    chk("fl_vld",   {63'd0, outValid}, 64'd0);
    chk("fl_ready", {63'd0, inReady},  64'd1);
    chk("fl_stale_tag", {58'd0, outTag}, 64'd7);
    chk("fl_stale_rn",  outRn, 64'h7);
    outReady = 1'b1;
    step();
    chk("fl_drop1", {63'd0, outValid}, 64'd0);
    step();
    chk("fl_drop2", {63'd0, outValid}, 64'd0);

    // Asynchronous reset with both stages full
    outReady = 1'b0;
    inValid = 1'b1; inRs = 64'h55; inRt = 8'h01; inOp = 3'd1; inTag = 6'd20;
    step();
    inTag = 6'd21;
    step();
    inValid = 1'b0;
    chk("mr_full_rdy", {63'd0, inReady},  64'd0);
    chk("mr_full_rn",  outRn, 64'hAA);
    #2;
    reset = 1'b0;
    #1;
    chk("mr_vld",   {63'd0, outValid}, 64'd0);
    chk("mr_ready", {63'd0, inReady},  64'd1);
    chk("mr_rn",    outRn, 64'd0);
    chk("mr_tag",   {58'd0, outTag}, 64'd0);
    step();
    reset = 1'b1;
    outReady = 1'b1;
    step();
    chk("mr_after_vld", {63'd0, outValid}, 64'd0);
    run_op("post_rst", 64'h1, 8'h01, 3'd1, 6'd22, 64'h2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/ex_shad_pipe64.md
Name: ex_shad_pipe64

Overview:
- Two-stage pipelined 64-bit SHLD/SHAD execute slot, directly downstream of the decode/operand-read stage.
- Stage 1 registers the issued operands. The shift is computed between stage 1 and stage 2, and stage 2 registers the result for writeback.
- Valid/ready handshakes on both sides, full throughput, backpressure from writeback, and a synchronous flush from branch/exception logic.

Parameters:
TAG_W, 6, width of the destination-register tag carried alongside each operation

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous kill of all in-flight operations
inValid  in  1  issue request
inReady  out  1  stage 1 can accept this cycle
inRs  in  64  source value
inRt  in  8  signed shift count
inOp  in  3  0 pass, 1 SHLD, 2 SHAD, 3 SHLDR, 4 SHADR, 5-7 pass
inTag  in  TAG_W  destination tag
outValid  out  1  result available
outReady  in  1  writeback accepts the result
outRn  out  64  shifted result
outTag  out  TAG_W  tag of the result

Behaviour:
- Reset asserted (reset=0): s1Valid=0, s2Valid=0, outValid=0, outRn=0, outTag=0, all operand registers 0. Reset takes effect immediately, including mid-operation; in-flight operations are lost.
- Handshake:
  - s2Free = !s2Valid | outReady
  - inReady = !s1Valid | s2Free (combinational)
  - Issue fires when inValid & inReady; the operand, count, op and tag are latched into stage 1.
  - Stage 1 advances to stage 2 when s1Valid & s2Free.
- Latency: an issue accepted at edge N produces outValid=1 after edge N+1 when not stalled. Sustained throughput is one operation per clock.
- Hold: while outValid & !outReady, outRn and outTag are stable and stage 2 holds. Stage 1 holds if full, and inReady=0 when both stages are full.
- Flush: at the edge where flush=1, s1Valid=0 and s2Valid=0. Flush wins over a simultaneous issue and a simultaneous advance; that issue is dropped. outRn and outTag keep their stale data but outValid=0.
- Shift count:
  - Ops 3 and 4 use sh = (-inRt) mod 256; all other ops use sh = inRt. Op 0 and ops 5-7 force sh = 0.
  - Bit 6 of sh is ignored.
  - sh[7]=0: left shift by sh[5:0] (0..63), zero fill.
  - sh[7]=1: right shift by 64 - sh[5:0] (1..64).
- Right-shift fill: zero for SHLD/SHLDR. For SHAD/SHADR the fill is inRs[63], replicated across all 64 bits.
- Boundaries:
  - sh = 0x80: shift right by 64. Result is 0 (logical) or the sign replica (arithmetic).
  - sh = 0x40: treated as 0; result = inRs.
  - Count -128 negated (ops 3/4) stays 0x80, i.e. right shift by 64.

Optional Feature:
- Macro EXSHAD_TBIT_EN.
- When defined, adds output outT (1 bit, reset 0), registered alongside outRn, equal to the last bit shifted out:
  - left by n (1..63): inRs[64-n]
  - right by m (1..63): inRs[m-1]
  - right by 64: inRs[63]
  - no shift: 0
- outT obeys the same hold and flush rules as outRn.
- When undefined, the port and its logic do not exist.

Test Plan:
- Reset mid-stream with both stages full -> outValid=0, inReady=1, outRn=0 immediately, before any clock edge.
- SHLD inRs=0x0000_0000_0000_0001, inRt=0x3F -> outRn=0x8000_0000_0000_0000 two edges after issue. With EXSHAD_TBIT_EN, issue inRs=0x0000_0000_0000_0003, inRt=0x3F -> outT=1.
- SHAD inRs=0x8000_0000_0000_0000, inRt=0xC0 (right by 64) -> outRn=0xFFFF_FFFF_FFFF_FFFF. SHADR with inRt=0x04 -> outRn=0xF800_0000_0000_0000.
- Back-to-back issues of tags 1,2,3 with outReady=0 -> inReady drops after 2 accepts; outTag=1 held stable. Raise outReady -> tags 1,2,3 drain in order, one per cycle, with no loss or duplication.
- flush=1 on the same cycle as an issue while stage 2 is valid -> outValid=0 next cycle; the issued tag never appears at the output.
- Op 6 with inRt=0x05, inRs=0x1234 -> outRn=0x1234. SHLD with inRt=0x40 -> outRn=inRs unchanged.
